// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - parametrised streaming CRC generator/checker with valid/ready framing
// Optional CRC_CHECK_EN adds the crc_match residue comparator and the RESIDUE parameter.
module crc_stream_engine #(
  parameter int          CRC_W  = 32,
  parameter int          DATA_W = 8,
  parameter logic [63:0] POLY   = 64'h0000_0000_04C1_1DB7,
  parameter logic [63:0] INIT   = 64'h0000_0000_FFFF_FFFF,
`ifdef CRC_CHECK_EN
  parameter logic [63:0] RESIDUE = 64'h0,
`endif
  parameter logic [63:0] XOROUT = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              crc_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic [15:0]       beat_cnt,
`ifdef CRC_CHECK_EN
  output logic              crc_match,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [CRC_W-1:0] P_POLY = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P_INIT = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] P_XOR  = XOROUT[CRC_W-1:0];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CRC_W-1:0]   r_lfsr;
  logic [CRC_W-1:0]   r_crc;
  logic [15:0]        r_cnt;
  logic [CRC_W-1:0]   w_lfsr_nxt;
  logic               w_accept;

  // Whole beat folded in one cycle, MSB of the beat first.
  function automatic logic [CRC_W-1:0] f_step(input logic [CRC_W-1:0] c,
                                              input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (r[CRC_W-1] ^ d[i]) r = (r << 1) ^ P_POLY;
      else                   r = r << 1;
    end
    return r;
  endfunction

  assign w_lfsr_nxt = f_step(r_lfsr, in_data);
  assign in_ready   = !clear && (r_state != S_HOLD);
  assign w_accept   = in_valid && in_ready;
  assign crc_valid  = (r_state == S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign crc_out    = r_crc;
  assign beat_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_RUN: if (w_accept) w_state_nxt = in_last ? S_HOLD : S_RUN;
        S_HOLD:        if (out_ready) w_state_nxt = S_IDLE;
        default:       w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= P_INIT;
      r_crc  <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_lfsr <= P_INIT;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_nxt;
      if (r_state == S_IDLE)    r_cnt <= 16'd1;
      else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      if (in_last) r_crc <= w_lfsr_nxt ^ P_XOR;
    end else if ((r_state == S_HOLD) && out_ready) begin
      r_lfsr <= P_INIT;
    end
  end

`ifdef CRC_CHECK_EN
  logic r_match;
  assign crc_match = r_match;

  // Compared against the raw remainder, before the output XOR is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_match <= 1'b0;
    else if (clear)                             r_match <= 1'b0;
    else if (w_accept && in_last)               r_match <= (w_lfsr_nxt == RESIDUE[CRC_W-1:0]);
    else if ((r_state == S_HOLD) && out_ready)  r_match <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - randomized self-checking bench for crc_stream_engine
// Three instances: CRC-32/8-bit beats, CRC-32/4-bit beats, CRC-16/8-bit beats.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_v = '0, in_l = '0;
  logic [2:0]  rdy, cv, bz;
  logic [7:0]  d0 = '0, d2 = '0;
  logic [3:0]  d1 = '0;
  logic [31:0] crc0, crc1;
  logic [15:0] crc2;
  logic [15:0] cnt [3];
`ifdef CRC_CHECK_EN
  logic        match0, match1, match2;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] m_std[$];

  always #5 clk = ~clk;

  crc_stream_engine u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_v[0]), .in_ready(rdy[0]),
    .in_data(d0), .in_last(in_l[0]), .crc_valid(cv[0]), .out_ready(out_ready),
    .crc_out(crc0), .beat_cnt(cnt[0]),
`ifdef CRC_CHECK_EN
    .crc_match(match0),
`endif
    .busy(bz[0]));

  crc_stream_engine #(.DATA_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_v[1]), .in_ready(rdy[1]),
    .in_data(d1), .in_last(in_l[1]), .crc_valid(cv[1]), .out_ready(out_ready),
    .crc_out(crc1), .beat_cnt(cnt[1]),
`ifdef CRC_CHECK_EN
    .crc_match(match1),
`endif
    .busy(bz[1]));

  crc_stream_engine #(.CRC_W(16), .POLY(64'h1021), .INIT(64'hFFFF)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_v[2]), .in_ready(rdy[2]),
    .in_data(d2), .in_last(in_l[2]), .crc_valid(cv[2]), .out_ready(out_ready),
    .crc_out(crc2), .beat_cnt(cnt[2]),
`ifdef CRC_CHECK_EN
    .crc_match(match2),
`endif
    .busy(bz[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] g_crc(input int idx);
    case (idx)
      0:       return {32'h0, crc0};
      1:       return {32'h0, crc1};
      default: return {48'h0, crc2};
    endcase
  endfunction

  function automatic int g_w(input int idx);
    return (idx == 2) ? 16 : 32;
  endfunction

  function automatic logic [63:0] g_poly(input int idx);
    return (idx == 2) ? 64'h1021 : 64'h04C11DB7;
  endfunction

  function automatic logic [63:0] g_init(input int idx);
    return (idx == 2) ? 64'hFFFF : 64'hFFFFFFFF;
  endfunction

  // Reference: mod-2 long division of M(x)*x^w + I(x)*x^L by the full generator.
  function automatic logic [63:0] ref_raw(input int w, input logic [63:0] poly,
                                          input logic [63:0] init, input logic [7:0] msg[$]);
    bit b[$];
    logic [63:0] r;
    int len;
    foreach (msg[i]) for (int k = 7; k >= 0; k--) b.push_back(msg[i][k]);
    len = b.size();
    repeat (w) b.push_back(1'b0);
    for (int k = 0; k < w; k++) b[k] = b[k] ^ init[w-1-k];
    for (int i = 0; i < len; i++)
      if (b[i]) for (int j = 0; j <= w; j++) b[i+j] = b[i+j] ^ ((j == 0) ? 1'b1 : poly[w-j]);
    r = '0;
    for (int j = 0; j < w; j++) r[w-1-j] = b[len+j];
    return r;
  endfunction

  task automatic drive(input int idx, input logic v, input logic [7:0] d, input logic l);
    in_v[idx] = v;
    in_l[idx] = l;
    case (idx)
      0:       d0 = d;
      1:       d1 = d[3:0];
      default: d2 = d;
    endcase
  endtask

  // Returns on the falling edge right after the posedge that took the final beat.
  task automatic send(input int idx, input logic [7:0] msg[$], input int stall, input bit last_en);
    logic [7:0] beats[$];
    foreach (msg[i]) begin
      if (idx == 1) begin
        beats.push_back({4'h0, msg[i][7:4]});
        beats.push_back({4'h0, msg[i][3:0]});
      end else beats.push_back(msg[i]);
    end
    foreach (beats[i]) begin
      if (stall > 0) repeat ($urandom_range(0, stall)) begin
        @(negedge clk); drive(idx, 1'b0, 8'h00, 1'b0);
      end
      @(negedge clk);
      drive(idx, 1'b1, beats[i], last_en && (i == beats.size() - 1));
    end
    @(negedge clk);
    drive(idx, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rand_frame(input int idx);
    logic [7:0] msg[$];
    int n, dly, beats;
    n = $urandom_range(1, 12);
    repeat (n) msg.push_back(8'($urandom));
    beats = (idx == 1) ? 2 * n : n;
    out_ready = 1'b0;
    send(idx, msg, 2, 1'b1);
    check($sformatf("rnd%0d_valid", idx), 64'(cv[idx]), 64'd1);
    check($sformatf("rnd%0d_crc", idx), g_crc(idx), ref_raw(g_w(idx), g_poly(idx), g_init(idx), msg));
    check($sformatf("rnd%0d_cnt", idx), 64'(cnt[idx]), 64'(beats));
    dly = $urandom_range(0, 3);
    repeat (dly) begin
      @(negedge clk);
      check($sformatf("rnd%0d_hold", idx), 64'(cv[idx]), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("rnd%0d_release", idx), 64'(cv[idx]), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    for (int i = 0; i < 9; i++) m_std.push_back(8'h31 + 8'(i));

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(cv[0]), 64'd0);
    check("rst_crc", g_crc(0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(rdy), 64'h7);
    check("rst_busy", 64'(bz), 64'h0);
    check("rst_cnt", 64'(cnt[0]), 64'd0);

    // Reference vector with out_ready high: one-cycle crc_valid pulse.
    out_ready = 1'b1;
    send(0, m_std, 0, 1'b1);
    check("t1_valid", 64'(cv[0]), 64'd1);
    check("t1_crc", g_crc(0), 64'h0376E6E7);
    check("t1_cnt", 64'(cnt[0]), 64'd9);
    check("t1_ready_hold", 64'(rdy[0]), 64'd0);
    @(negedge clk);
    check("t1_pulse", 64'(cv[0]), 64'd0);
    check("t1_busy", 64'(bz[0]), 64'd0);
    check("t1_crc_kept", g_crc(0), 64'h0376E6E7);
    check("t1_cnt_kept", 64'(cnt[0]), 64'd9);

    send(1, m_std, 0, 1'b1);
    check("t2_crc", g_crc(1), 64'h0376E6E7);
    check("t2_cnt", 64'(cnt[1]), 64'd18);
    send(2, m_std, 0, 1'b1);
    check("t3_crc", g_crc(2), 64'h29B1);
    check("t3_cnt", 64'(cnt[2]), 64'd9);
    @(negedge clk);

    // Back-pressure on the result: input ignored while holding.
    out_ready = 1'b0;
    send(0, m_std, 1, 1'b1);
    held = crc0;
    check("t4_crc", 64'(held), 64'h0376E6E7);
    repeat (5) begin
      drive(0, 1'b1, 8'($urandom), 1'($urandom));
      @(negedge clk);
      check("t4_hold_valid", 64'(cv[0]), 64'd1);
      check("t4_hold_crc", g_crc(0), 64'(held));
      check("t4_hold_ready", 64'(rdy[0]), 64'd0);
    end
    drive(0, 1'b0, 8'h00, 1'b0);
    check("t4_hold_cnt", 64'(cnt[0]), 64'd9);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_idle", 64'(bz[0]), 64'd0);
    check("t4_valid_low", 64'(cv[0]), 64'd0);
    send(0, m_std, 0, 1'b1);
    check("t4_again", g_crc(0), 64'h0376E6E7);
    @(negedge clk);

    // Abort with clear after a partial frame.
    send(0, m_std[0:3], 0, 1'b0);
    check("t5_partial_cnt", 64'(cnt[0]), 64'd4);
    clear = 1'b1;
    drive(0, 1'b1, 8'h55, 1'b0);
    #1 check("t5_clear_ready", 64'(rdy[0]), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    check("t5_clear_cnt", 64'(cnt[0]), 64'd0);
    check("t5_clear_busy", 64'(bz[0]), 64'd0);
    send(0, m_std, 0, 1'b1);
    check("t5_crc", g_crc(0), 64'h0376E6E7);
    check("t5_cnt", 64'(cnt[0]), 64'd9);
    @(negedge clk);

    // Asynchronous reset mid-frame, then in HOLD.
    send(0, m_std[0:2], 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(bz[0]), 64'd0);
    check("t5_rst_cnt", 64'(cnt[0]), 64'd0);
    check("t5_rst_crc", g_crc(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    send(0, m_std, 0, 1'b1);
    check("t5_hold_pre", 64'(cv[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_hold_rst_valid", 64'(cv[0]), 64'd0);
    check("t5_hold_rst_ready", 64'(rdy[0]), 64'd1);
    check("t5_hold_rst_crc", g_crc(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) rand_frame(0);
    for (int i = 0; i < 5; i++) rand_frame(1);
    for (int i = 0; i < 5; i++) rand_frame(2);

`ifdef CRC_CHECK_EN
    begin
      logic [7:0] msg[$];
      logic [63:0] exp_m;
      int pos;
      msg = m_std;
      msg.push_back(8'h03); msg.push_back(8'h76); msg.push_back(8'hE6); msg.push_back(8'hE7);
      for (int t = 0; t < 4; t++) begin
        if (t > 0) begin
          msg = m_std;
          msg.push_back(8'h03); msg.push_back(8'h76); msg.push_back(8'hE6); msg.push_back(8'hE7);
          pos = $urandom_range(0, 12);
          msg[pos] = msg[pos] ^ 8'($urandom_range(1, 255));
        end
        exp_m = (ref_raw(32, 64'h04C11DB7, 64'hFFFFFFFF, msg) == 64'd0) ? 64'd1 : 64'd0;
        if (t == 0) check("t6_exp_good", exp_m, 64'd1);
        out_ready = 1'b0;
        send(0, msg, 1, 1'b1);
        check("t6_match", 64'(match0), exp_m);
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_match_low", 64'(match0), 64'd0);
      end
      out_ready = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised, streaming CRC generator/checker; successor to the fixed 32-bit, 4-bit-per-cycle CRC-32 LFSR.
- Generalises CRC width, polynomial, init value, final XOR and data-beat width.
- Adds valid/ready framing with a last-beat marker, a registered result handshake and a beat counter.
- Sits between a byte/nibble stream source (UART/Ethernet-style front end) and the consumer of frame CRCs.

Parameters:
- CRC_W, 32, CRC register width (8..64).
- DATA_W, 8, data bits consumed per accepted beat (1..64).
- POLY, 32'h04C11DB7, generator polynomial, implicit x^CRC_W term omitted.
- INIT, 32'hFFFFFFFF, register value at frame start.
- XOROUT, 32'h00000000, XORed into the final remainder to form crc_out.
- RESIDUE, 32'h00000000, expected raw remainder for check mode (used only with CRC_CHECK_EN).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous abort/reinit, highest priority.
- in_valid, input, 1, data beat offered.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- in_data, input, DATA_W, beat payload; bit DATA_W-1 is processed first.
- in_last, input, 1, marks final beat of frame.
- crc_valid, output, 1, result available.
- out_ready, input, 1, consumer takes result when crc_valid && out_ready.
- crc_out, output, CRC_W, final CRC = remainder ^ XOROUT.
- beat_cnt, output, 16, beats accepted in current/last frame, saturating at 16'hFFFF.
- busy, output, 1, high in RUN or HOLD.

Behaviour:
- Reset (rst_n low, async): state IDLE; lfsr=INIT; crc_out=0; crc_valid=0; beat_cnt=0; busy=0; in_ready=1 once released.
- Per-bit update, applied DATA_W times combinationally per beat, MSB of in_data first:
  - fb = lfsr[CRC_W-1] ^ bit
  - lfsr = (lfsr << 1) ^ (fb ? POLY : 0), truncated to CRC_W.
- Beat processing is single-cycle; full throughput is one beat per clock.
- in_ready = !clear && (state != HOLD).
- FSM:
  - IDLE: lfsr holds INIT. An accepted beat updates lfsr and sets beat_cnt=1. With in_last, go to HOLD; otherwise go to RUN.
  - RUN: each accepted beat updates lfsr and increments beat_cnt (saturating). An in_last beat goes to HOLD. in_valid low means stall; state is held.
  - HOLD: crc_valid=1 and crc_out is stable. Input is ignored. On out_ready, go to IDLE next cycle with crc_valid=0 and lfsr=INIT.
- Latency: the last beat accepted in cycle N gives crc_valid=1 and a valid crc_out in cycle N+1. Single-beat frames are legal.
- crc_out and beat_cnt hold their value after the handshake until the next frame completes or the next first beat is accepted (beat_cnt only).
- clear (any state): next cycle state=IDLE, lfsr=INIT, crc_valid=0, beat_cnt=0. A beat offered in the same cycle is not accepted; in_ready=0 that cycle.
- out_ready in IDLE or RUN is ignored.
- rst_n assertion mid-frame or in HOLD immediately forces all reset values.

Optional Feature:
- Macro: CRC_CHECK_EN.
- Defined:
  - Adds output port crc_match (1 bit).
  - crc_match is registered with crc_valid: 1 when the raw remainder (before XOROUT) == RESIDUE[CRC_W-1:0], else 0.
  - crc_match is 0 whenever crc_valid=0 and resets to 0.
- Not defined: the port and comparator are absent; all other behaviour is identical.

Test Plan:
1. Defaults (CRC_W=32, DATA_W=8), stream ASCII "123456789" (0x31..0x39, last on 0x39), out_ready=1 -> crc_valid for exactly 1 cycle, one cycle after the last beat; crc_out=32'h0376E6E7; beat_cnt=9.
2. DATA_W=4, same message as 18 nibbles (high nibble first) -> crc_out=32'h0376E6E7; beat_cnt=18.
3. CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, XOROUT=0, "123456789" -> crc_out=16'h29B1.
4. Defaults, out_ready held low 5 cycles after the result -> crc_valid and crc_out stable, in_ready=0, input beats ignored; on out_ready=1, IDLE next cycle; a following "123456789" again gives 32'h0376E6E7.
5. Feed "1234", pulse clear, then "123456789"; separately assert rst_n low mid-frame -> clear case gives crc_out=32'h0376E6E7, beat_cnt=9; rst_n case sets all outputs to reset values asynchronously.
6. CRC_CHECK_EN, RESIDUE=0: "123456789" followed by 0x03,0x76,0xE6,0xE7 -> crc_match=1. Flipping any byte gives crc_match=0.
